// File: rtl/cnt_cmp_pkg.sv
// cnt_cmp_pkg: shared state/class types and constants for the counter compare unit
package cnt_cmp_pkg;
    localparam int W_DEF = 12;
    localparam logic [W_DEF-1:0] CNT_MAX = {W_DEF{1'b1}};
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, HIT = 2'd2} state_t;
    typedef enum logic [1:0] {HOLD = 2'd0, STEP = 2'd1, WRAP = 2'd2, JUMP = 2'd3} cls_t;
endpackage

// File: rtl/cnt_step_classifier.sv
// cnt_step_classifier: remembers the previous count and registers the hold/step/wrap/jump class
module cnt_step_classifier
    import cnt_cmp_pkg::*;
#(
    parameter int W = 12
) (
    input  logic         clck,
    input  logic         rst,
    input  logic [W-1:0] cnt_in,
    output logic [W-1:0] prev,
    output logic         prev_vld,
    output cls_t         cls,
    output logic         cls_vld
);
    logic [W-1:0] prev_q, prev_d;
    logic         prev_vld_q, prev_vld_d;
    cls_t         cls_q, cls_d;
    logic         cls_vld_q, cls_vld_d;

    // classify the incoming sample against the previous one; max value only wraps to zero
    always_comb begin
        prev_d     = cnt_in;
        prev_vld_d = 1'b1;
        cls_vld_d  = prev_vld_q;
        cls_d      = (cnt_in == prev_q) ? HOLD :
                     (prev_q == {W{1'b1}}) ? ((cnt_in == '0) ? WRAP : JUMP) :
                     (cnt_in == prev_q + W'(1)) ? STEP : JUMP;
    end

    // sample history and class registers
    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            cls_q      <= HOLD;
            cls_vld_q  <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            cls_q      <= cls_d;
            cls_vld_q  <= cls_vld_d;
        end
    end

    assign prev     = prev_q;
    assign prev_vld = prev_vld_q;
    assign cls      = cls_q;
    assign cls_vld  = cls_vld_q;
endmodule

// File: rtl/cnt_compare_unit.sv
// cnt_compare_unit: compare FSM, match counter and transition pulses; CNT_CMP_WINDOW_EN adds a window output
module cnt_compare_unit
    import cnt_cmp_pkg::*;
#(
    parameter int W       = 12,
    parameter int MCNT_W  = 8,
    parameter int ONESHOT = 0
) (
    input  logic              clck,
    input  logic              rst,
    input  logic [W-1:0]      cnt_in,
    input  logic              cmp_ld,
    input  logic [W-1:0]      cmp_in,
    input  logic              clr,
`ifdef CNT_CMP_WINDOW_EN
    input  logic              win_ld,
    input  logic [W-1:0]      win_hi,
    output logic              in_window,
`endif
    output logic              match_pulse,
    output logic              wrap_pulse,
    output logic              jump_pulse,
    output logic [MCNT_W-1:0] match_cnt,
    output logic              armed,
    output logic              hit
);
    logic [W-1:0]      prev;
    logic              prev_vld;
    cls_t              cls;
    logic              cls_vld;
    state_t            state_q, state_d;
    logic [W-1:0]      cmp_val_q, cmp_val_d;
    logic [MCNT_W-1:0] match_cnt_q, match_cnt_d;
    logic              match_pulse_q, match_pulse_d;
    logic              arrival;
    logic              fire;

    cnt_step_classifier #(.W(W)) u_cls (
        .clck     (clck),
        .rst      (rst),
        .cnt_in   (cnt_in),
        .prev     (prev),
        .prev_vld (prev_vld),
        .cls      (cls),
        .cls_vld  (cls_vld)
    );

    // arrival uses the compare value held before this edge; a held count never re-matches
    always_comb begin
        arrival       = prev_vld && (cnt_in != prev) && (cnt_in == cmp_val_q);
        fire          = arrival && (state_q == ARMED);
        match_pulse_d = fire;
        cmp_val_d     = cmp_ld ? cmp_in : cmp_val_q;
        match_cnt_d   = clr ? '0 :
                        (fire && match_cnt_q != {MCNT_W{1'b1}}) ? match_cnt_q + MCNT_W'(1) : match_cnt_q;
        state_d       = (fire && ONESHOT != 0) ? HIT : state_q;
        state_d       = (clr && state_q == HIT) ? ARMED : state_d;
        state_d       = cmp_ld ? ARMED : state_d;
    end

    // FSM, compare register, match counter and match pulse
    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cmp_val_q     <= '0;
            match_cnt_q   <= '0;
            match_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmp_val_q     <= cmp_val_d;
            match_cnt_q   <= match_cnt_d;
            match_pulse_q <= match_pulse_d;
        end
    end

`ifdef CNT_CMP_WINDOW_EN
    logic [W-1:0] win_hi_q, win_hi_d;
    logic         in_window_q, in_window_d;

    // window bound load and registered range test; empty when the bound is below cmp_val
    always_comb begin
        win_hi_d    = win_ld ? win_hi : win_hi_q;
        in_window_d = (cnt_in >= cmp_val_q) && (cnt_in <= win_hi_q);
    end

    // window registers
    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            win_hi_q    <= {W{1'b1}};
            in_window_q <= 1'b0;
        end else begin
            win_hi_q    <= win_hi_d;
            in_window_q <= in_window_d;
        end
    end

    assign in_window = in_window_q;
`endif

    assign match_pulse = match_pulse_q;
    assign wrap_pulse  = cls_vld && (cls == WRAP);
    assign jump_pulse  = cls_vld && (cls == JUMP);
    assign match_cnt   = match_cnt_q;
    assign armed       = (state_q == ARMED);
    assign hit         = (state_q == HIT);
endmodule

// File: tb/tb_cnt_compare_unit.sv
// tb_cnt_compare_unit: directed scoreboard bench for cnt_compare_unit (re-trigger and one-shot instances)
module tb_cnt_compare_unit;
    logic        clck;
    logic        rst;
    logic [11:0] cnt_in;
    logic        cmp_ld;
    logic [11:0] cmp_in;
    logic        clr;
    logic        mp0, wp0, jp0, ar0, ht0;
    logic [7:0]  mc0;
    logic        mp1, wp1, jp1, ar1, ht1;
    logic [7:0]  mc1;
    int          checks;
    int          errors;

    typedef struct {
        int m, w, j, mc, a, h, k, m1, mc1, a1, h1;
    } exp_t;
    exp_t q[$];

    cnt_compare_unit #(.W(12), .MCNT_W(8), .ONESHOT(0)) dut (
        .clck(clck), .rst(rst), .cnt_in(cnt_in), .cmp_ld(cmp_ld), .cmp_in(cmp_in), .clr(clr),
        .match_pulse(mp0), .wrap_pulse(wp0), .jump_pulse(jp0), .match_cnt(mc0), .armed(ar0), .hit(ht0)
    );

    cnt_compare_unit #(.W(12), .MCNT_W(8), .ONESHOT(1)) dut1 (
        .clck(clck), .rst(rst), .cnt_in(cnt_in), .cmp_ld(cmp_ld), .cmp_in(cmp_in), .clr(clr),
        .match_pulse(mp1), .wrap_pulse(wp1), .jump_pulse(jp1), .match_cnt(mc1), .armed(ar1), .hit(ht1)
    );

    initial begin
        clck = 1'b0;
        forever #5 clck = ~clck;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    task automatic st(input int c, input int ld, input int ci, input int cl,
                      input int m, input int w, input int j, input int mc, input int a, input int h,
                      input int k, input int m1, input int mcb, input int a1, input int h1);
        exp_t e;
        @(negedge clck);
        cnt_in = 12'(c);
        cmp_ld = ld[0];
        cmp_in = 12'(ci);
        clr    = cl[0];
        e = '{m: m, w: w, j: j, mc: mc, a: a, h: h, k: k, m1: m1, mc1: mcb, a1: a1, h1: h1};
        q.push_back(e);
    endtask

    always @(posedge clck) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("match_pulse", 32'(mp0), e.m);
            chk("wrap_pulse", 32'(wp0), e.w);
            chk("jump_pulse", 32'(jp0), e.j);
            chk("match_cnt", 32'(mc0), e.mc);
            chk("armed", 32'(ar0), e.a);
            chk("hit", 32'(ht0), e.h);
            if (e.k != 0) begin
                chk("os_match_pulse", 32'(mp1), e.m1);
                chk("os_wrap_pulse", 32'(wp1), e.w);
                chk("os_jump_pulse", 32'(jp1), e.j);
                chk("os_match_cnt", 32'(mc1), e.mc1);
                chk("os_armed", 32'(ar1), e.a1);
                chk("os_hit", 32'(ht1), e.h1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        cnt_in = '0;
        cmp_ld = 1'b0;
        cmp_in = '0;
        clr = 1'b0;
        #1;
        chk("rst_match", 32'(mp0), 0);
        chk("rst_wrap", 32'(wp0), 0);
        chk("rst_jump", 32'(jp0), 0);
        chk("rst_cnt", 32'(mc0), 0);
        chk("rst_armed", 32'(ar0), 0);
        chk("rst_hit", 32'(ht0), 0);
        @(posedge clck);
        #2 rst = 1'b0;
        // arm at 5 and step 0..10
        st(0, 1, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++)
            st(i, 0, 0, 0, int'(i == 5), 0, 0, int'(i >= 5), 1, 0, 0, 0, 0, 0, 0);
        // re-arm at 5 with clear, then hold at 5
        st(10, 1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        st(5, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) st(5, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        // wrap onto compare value 0
        st(5, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        st(4094, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        st(4095, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        st(0, 0, 0, 0, 1, 1, 0, 2, 1, 0, 0, 0, 0, 0, 0);
        st(1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0);
        // jumps
        st(10, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0);
        st(11, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0);
        st(102, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0);
        st(23, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0);
        // asynchronous reset mid-count
        @(negedge clck);
        cnt_in = 12'd0;
        #2 rst = 1'b1;
        #1;
        chk("arst_match", 32'(mp0), 0);
        chk("arst_jump", 32'(jp0), 0);
        chk("arst_cnt", 32'(mc0), 0);
        chk("arst_armed", 32'(ar0), 0);
        chk("arst_os_cnt", 32'(mc1), 0);
        chk("arst_os_hit", 32'(ht1), 0);
        repeat (2) @(posedge clck);
        #2 rst = 1'b0;
        st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        st(7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        // one-shot versus re-trigger at compare value 3
        st(7, 1, 3, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
        st(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0);
        st(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
        st(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
        st(3, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 1, 1, 0, 1);
        st(4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 1);
        st(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 1, 0, 1);
        st(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 1);
        st(2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 1);
        st(3, 0, 0, 0, 1, 0, 0, 2, 1, 0, 1, 0, 1, 0, 1);
        st(4, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0, 1, 0, 1);
        st(4, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
        st(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0);
        st(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
        st(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
        st(3, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 1, 1, 0, 1);
        // clr with arrival, then load with old-value compare
        st(2, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 1, 0, 1);
        st(3, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
        st(4, 1, 4, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
        st(5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
        st(4, 0, 0, 0, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 1);
        repeat (3) @(negedge clck);
        chk("scoreboard_drain", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cnt_compare_unit.md
Name: cnt_compare_unit

Overview:
- Downstream stage of the 12-bit loadable up-counter. Samples the counter output every clock and classifies each transition as hold, step, wrap or jump.
- Raises a registered pulse when the count newly arrives at a programmed compare value, and keeps a saturating count of matches.
- Feeds LED/indicator logic and any event-driven sequencing in the lab design.

Parameters:
- W, 12, width of the counter value and compare register.
- MCNT_W, 8, width of the saturating match counter.
- ONESHOT, 0: 1 = stop after the first match (enter HIT), 0 = re-trigger on every arrival.

Ports:
- clck  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cnt_in  in  W  counter output being monitored.
- cmp_ld  in  1  load cmp_in into the compare register and arm.
- cmp_in  in  W  compare value.
- clr  in  1  clear the match count and re-arm from HIT.
- match_pulse  out  1  one-cycle pulse on a new arrival at the compare value.
- wrap_pulse  out  1  one-cycle pulse on a 4095->0 transition.
- jump_pulse  out  1  one-cycle pulse on a non-sequential change (load or counter reset).
- match_cnt  out  MCNT_W  saturating match count.
- armed  out  1  high while state is ARMED.
- hit  out  1  high while state is HIT.

Behaviour:
- Reset (async, rst=1): all pulses 0, match_cnt=0, cmp_val=0, prev=0, prev_vld=0, state=IDLE (armed=0, hit=0).
- Sampling: prev<=cnt_in every cycle; prev_vld<=1 on the first clock after reset deasserts.
- Classification, only when prev_vld=1:
  - hold: cnt_in==prev.
  - step: cnt_in==prev+1 and prev!=2^W-1.
  - wrap: prev==2^W-1 and cnt_in==0.
  - jump: any other change.
- With prev_vld=0 there is no classification and no pulses.
- Output latency: all pulses are registered and assert on the clock edge that samples the event, so they are visible the cycle after cnt_in changes. Each pulse lasts exactly one cycle.
- Arrival: prev_vld=1, cnt_in!=prev, and cnt_in==cmp_val. A held count never re-matches.
- FSM:
  - IDLE: cmp_ld -> ARMED.
  - ARMED: arrival -> match_pulse=1, match_cnt+=1 (saturates at 2^MCNT_W-1). Then -> HIT if ONESHOT=1, else stay ARMED.
  - HIT: arrivals ignored. clr -> ARMED.
  - Any state: cmp_ld -> cmp_val<=cmp_in, state -> ARMED.
- The compare uses cmp_val as registered before the edge. A cmp_ld and an arrival in the same cycle compare against the old value; the new value takes effect next cycle.
- clr: match_cnt<=0; HIT -> ARMED; no effect on the state in IDLE or ARMED.
- clr together with an arrival in the same cycle: clr wins, match_cnt=0, but match_pulse still fires.
- cmp_ld together with clr: both apply.
- A wrap landing on cmp_val=0 produces both wrap_pulse and match_pulse. A jump onto cmp_val produces both jump_pulse and match_pulse.
- rst mid-operation: immediate return to reset values. After release the next sample is unclassified.

Optional Feature:
- Macro: CNT_CMP_WINDOW_EN.
- Defined: adds inputs win_ld (1 bit) and win_hi (W bits) plus output in_window (1 bit, registered).
  - win_ld loads the upper bound win_hi into a register.
  - in_window=1 while cmp_val<=cnt_in<=win_hi; it is 0 if win_hi<cmp_val.
  - Reset value of in_window is 0, and of the upper bound is 2^W-1.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package cnt_cmp_pkg:
  - FSM state typedef (IDLE, ARMED, HIT).
  - Transition-class typedef (HOLD, STEP, WRAP, JUMP).
  - Constant CNT_MAX = 2^W-1 for the default W.
- Sub-module cnt_step_classifier: holds prev/prev_vld and outputs the registered class. The top instantiates it and contains the FSM, compare logic and match counter.

Test Plan:
- Reset, cmp_ld with cmp_in=5, cnt_in stepping 0..10 at one count per cycle -> one match_pulse the cycle after cnt_in=5, match_cnt=1, no jump or wrap pulses.
- cnt_in held at 5 for 4 cycles after arming at 5 -> exactly one match_pulse, match_cnt=1.
- cnt_in 4094, 4095, 0, 1 with cmp_val=0 -> wrap_pulse and match_pulse on the same cycle.
- cnt_in steps 10, 11, then loads to 102, then 23 -> jump_pulse on the 102 and 23 samples, none on 11.
- ONESHOT=1, cmp_val=3, counter cycles through 3 twice -> one pulse, hit=1 afterwards; clr -> hit=0, armed=1, match_cnt=0, next arrival at 3 pulses again.
- rst=1 asserted asynchronously mid-count with match_cnt=2 -> outputs zero immediately; first sample after release produces no pulse even if cnt_in=0.
